// File: rtl/bram_slot_poller.sv
// -----------------------------------------------------------------------------
// bram_slot_poller
//
// Round-robin read scheduler for the per-slot read port of the BRAM
// controller. Walks the enabled slots in index order, raises a one-hot read
// strobe for each one, and waits for that slot's read_done. The returned word
// goes into a local shadow bank. A slot that does not answer within TIMEOUT
// cycles is flagged in a sticky error vector. A pulse marks the end of each
// sweep. Downstream logic reads slot_values / slot_fresh and never touches the
// controller strobes.
//
// Ports
//   clk          in   clock, rising edge
//   rstn         in   synchronous active-low reset
//   read_data    in   controller read words, slot i at [i*WORD_W +: WORD_W]
//   read_done    in   controller per-slot read-complete
//   read_strobe  out  registered read request, zero or one-hot
//   run          in   level; sweeps repeat back-to-back while high
//   enable_mask  in   slots to poll, sampled per slot as it is scanned
//   err_clear    in   one-cycle pulse clearing timeout_err
//   slot_values  out  last captured word per slot
//   slot_fresh   out  slot captured during current / most recent sweep
//   timeout_err  out  sticky per-slot timeout flags
//   sweep_done   out  one-cycle pulse in the ADV cycle of the last slot
//   busy         out  high whenever the FSM is not idle
//   dbg_state    out  current FSM state (IDLE=0, SCAN=1, REQ=2, ADV=3)
//
// Handshake with the controller: read_strobe[idx] is held high from the cycle
// after SCAN until the cycle in which read_done[idx] is seen high (inclusive),
// or for TIMEOUT cycles. The read_done of the active slot is sampled on every
// REQ cycle, including the first. All other read_done bits are ignored.
// -----------------------------------------------------------------------------
module bram_slot_poller #(
  parameter int NUM_LOC = 4,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [WORD_W*NUM_LOC-1:0] read_data,
  input  logic [NUM_LOC-1:0]        read_done,
  output logic [NUM_LOC-1:0]        read_strobe,
  input  logic                      run,
  input  logic [NUM_LOC-1:0]        enable_mask,
  input  logic                      err_clear,
  output logic [WORD_W*NUM_LOC-1:0] slot_values,
  output logic [NUM_LOC-1:0]        slot_fresh,
  output logic [NUM_LOC-1:0]        timeout_err,
  output logic                      sweep_done,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int IW = $clog2(NUM_LOC);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LOC - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_ADV  = 2'd3
  } state_e;

  state_e                      state_q;
  logic [IW-1:0]               idx_q;
  logic [TW-1:0]               timer_q;
  logic [NUM_LOC-1:0]          strobe_q;
  logic [WORD_W*NUM_LOC-1:0]   values_q;
  logic [NUM_LOC-1:0]          fresh_q;
  logic [NUM_LOC-1:0]          err_q;
  logic                        sweep_done_q;
  logic                        restart;
  logic [NUM_LOC-1:0]          err_d;

  function automatic logic [NUM_LOC-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_LOC-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // A new sweep may start only with something to poll.
  assign restart = run && (|enable_mask);

  // err_clear acts first so a timeout landing in the same cycle still sticks.
  assign err_d = err_clear ? '0 : err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      strobe_q     <= '0;
      values_q     <= '0;
      fresh_q      <= '0;
      err_q        <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      err_q        <= err_d;
      case (state_q)
        S_IDLE: begin
          strobe_q <= '0;
          if (restart) begin
            idx_q   <= '0;
            fresh_q <= '0;
            state_q <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (enable_mask[idx_q]) begin
            strobe_q <= onehot(idx_q);
            timer_q  <= '0;
            state_q  <= S_REQ;
          end else begin
            // sweep_done is registered, so it is raised on entry to ADV.
            sweep_done_q <= (idx_q == LAST_IDX);
            state_q      <= S_ADV;
          end
        end

        S_REQ: begin
          // Done takes priority over a timeout in the same cycle.
          if (read_done[idx_q]) begin
            for (int i = 0; i < NUM_LOC; i++) begin
              if (idx_q == IW'(i)) begin
                values_q[i*WORD_W +: WORD_W] <= read_data[i*WORD_W +: WORD_W];
              end
            end
            fresh_q[idx_q] <= 1'b1;
            strobe_q       <= '0;
            sweep_done_q   <= (idx_q == LAST_IDX);
            state_q        <= S_ADV;
          end else if (timer_q == TIMER_LAST) begin
            err_q          <= err_d | onehot(idx_q);
            strobe_q       <= '0;
            sweep_done_q   <= (idx_q == LAST_IDX);
            state_q        <= S_ADV;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_ADV: begin
          strobe_q <= '0;
          if (idx_q == LAST_IDX) begin
            if (restart) begin
              idx_q   <= '0;
              fresh_q <= '0;
              state_q <= S_SCAN;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_SCAN;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_strobe = strobe_q;
  assign slot_values = values_q;
  assign slot_fresh  = fresh_q;
  assign timeout_err = err_q;
  assign sweep_done  = sweep_done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bram_slot_poller.sv
// -----------------------------------------------------------------------------
// Testbench for bram_slot_poller (NUM_LOC=4, WORD_W=32, TIMEOUT=8).
// A behavioural controller answers each strobe after a per-slot delay
// (delay 0 = never answers). A monitor accumulates strobe statistics. Each
// scenario task drives stimulus and checks hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_bram_slot_poller;

  localparam int NL = 4;
  localparam int WW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [WW*NL-1:0]  read_data;
  logic [NL-1:0]     read_done = '0;
  logic [NL-1:0]     read_strobe;
  logic              run;
  logic [NL-1:0]     enable_mask;
  logic              err_clear;
  logic [WW*NL-1:0]  slot_values;
  logic [NL-1:0]     slot_fresh;
  logic [NL-1:0]     timeout_err;
  logic              sweep_done;
  logic              busy;
  logic [1:0]        dbg_state;

  bram_slot_poller #(.NUM_LOC(NL), .WORD_W(WW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .read_data   (read_data),
    .read_done   (read_done),
    .read_strobe (read_strobe),
    .run         (run),
    .enable_mask (enable_mask),
    .err_clear   (err_clear),
    .slot_values (slot_values),
    .slot_fresh  (slot_fresh),
    .timeout_err (timeout_err),
    .sweep_done  (sweep_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- controller model + monitor ----------------
  logic [WW-1:0] data_cfg [NL];
  int            delay_cfg [NL];
  int            hi_cnt [NL]  = '{default: 0};
  int            tot_hi [NL]  = '{default: 0};
  int            multi_hot    = 0;
  int            sweep_cnt    = 0;
  int            rise_q[$];

  for (genvar g = 0; g < NL; g++) begin : g_data
    assign read_data[g*WW +: WW] = data_cfg[g];
  end

  always @(negedge clk) begin
    if ($countones(read_strobe) > 1) multi_hot++;
    if (sweep_done) sweep_cnt++;
    for (int i = 0; i < NL; i++) begin
      if (read_strobe[i]) begin
        if (hi_cnt[i] == 0) rise_q.push_back(i);
        hi_cnt[i]++;
        tot_hi[i]++;
      end else begin
        hi_cnt[i] = 0;
      end
      read_done[i] = read_strobe[i] && (delay_cfg[i] != 0) && (hi_cnt[i] == delay_cfg[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep; run stays high through tick run_ticks, err_clear is high
  // in the cycle after tick clear_at. Returns the tick on which sweep_done is
  // seen (tick 1 is the edge where IDLE samples run), or -1 on budget expiry.
  task automatic run_sweep(input int run_ticks, input int clear_at, output int done_n);
    int n;
    n      = 0;
    done_n = -1;
    run    = 1'b1;
    while (n < 300) begin
      tick();
      n++;
      if (n >= run_ticks) run = 1'b0;
      err_clear = (n == clear_at);
      if (sweep_done) begin
        done_n = n;
        break;
      end
    end
    run       = 1'b0;
    err_clear = 1'b0;
  endtask

  function automatic int rise_code(input int base);
    int c;
    c = 0;
    for (int j = base; j < rise_q.size(); j++) c = c * 10 + rise_q[j] + 1;
    return c;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; run = 1'b0; enable_mask = '0; err_clear = 1'b0;
    repeat (3) tick();
    total++; if (read_strobe !== 4'h0) begin bad++; $display("FAIL rst_strobe got=%h exp=0", read_strobe); end
    total++; if (slot_values !== '0) begin bad++; $display("FAIL rst_values got=%h exp=0", slot_values); end
    total++; if (slot_fresh !== 4'h0) begin bad++; $display("FAIL rst_fresh got=%h exp=0", slot_fresh); end
    total++; if (timeout_err !== 4'h0) begin bad++; $display("FAIL rst_err got=%h exp=0", timeout_err); end
    total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL rst_sweep_done got=%b exp=0", sweep_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rstn = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_empty_mask();
    int seen;
    seen = 0;
    run = 1'b1; enable_mask = 4'h0;
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || read_strobe !== 4'h0) seen++;
    end
    run = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL empty_mask_active got=%0d exp=0", seen); end
  endtask

  task automatic test_full_sweep();
    int n, b0, b1, b2, b3, br, bm, bs;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i] = 32'h11111111 * (i + 1);
      delay_cfg[i] = 2;
    end
    b0 = tot_hi[0]; b1 = tot_hi[1]; b2 = tot_hi[2]; b3 = tot_hi[3];
    br = rise_q.size(); bm = multi_hot; bs = sweep_cnt;
    enable_mask = 4'hF;
    run_sweep(1, -1, n);
    total++; if (n !== 16) begin bad++; $display("FAIL full_latency got=%0d exp=16", n); end
    total++; if (slot_values !== {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      bad++; $display("FAIL full_values got=%h exp=44444444333333332222222211111111", slot_values); end
    total++; if (slot_fresh !== 4'hF) begin bad++; $display("FAIL full_fresh got=%h exp=f", slot_fresh); end
    tick(); tick();
    total++; if (busy !== 1'b0 || read_strobe !== 4'h0) begin bad++; $display("FAIL full_idle got=%b/%h exp=0/0", busy, read_strobe); end
    total++; if (multi_hot - bm !== 0) begin bad++; $display("FAIL full_onehot got=%0d exp=0", multi_hot - bm); end
    total++; if (sweep_cnt - bs !== 1) begin bad++; $display("FAIL full_sweep_cnt got=%0d exp=1", sweep_cnt - bs); end
    total++; if ((tot_hi[0]-b0) !== 2 || (tot_hi[1]-b1) !== 2 || (tot_hi[2]-b2) !== 2 || (tot_hi[3]-b3) !== 2) begin
      bad++; $display("FAIL full_strobe_len got=%0d,%0d,%0d,%0d exp=2,2,2,2",
                      tot_hi[0]-b0, tot_hi[1]-b1, tot_hi[2]-b2, tot_hi[3]-b3); end
    total++; if (rise_code(br) !== 1234) begin bad++; $display("FAIL full_order got=%0d exp=1234", rise_code(br)); end
  endtask

  task automatic test_partial_mask();
    int n, b1, b3, br;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i] = 32'hAAAA0000 + i;
      delay_cfg[i] = 1;
    end
    b1 = tot_hi[1]; b3 = tot_hi[3]; br = rise_q.size();
    enable_mask = 4'b0101;
    run_sweep(1, -1, n);
    total++; if (n !== 10) begin bad++; $display("FAIL part_latency got=%0d exp=10", n); end
    total++; if (slot_values !== {32'h44444444, 32'hAAAA0002, 32'h22222222, 32'hAAAA0000}) begin
      bad++; $display("FAIL part_values got=%h exp=44444444aaaa000222222222aaaa0000", slot_values); end
    total++; if (slot_fresh !== 4'b0101) begin bad++; $display("FAIL part_fresh got=%b exp=0101", slot_fresh); end
    total++; if (rise_code(br) !== 13 || tot_hi[1] !== b1 || tot_hi[3] !== b3) begin
      bad++; $display("FAIL part_strobes got=%0d exp=13", rise_code(br)); end
    tick();
  endtask

  task automatic test_timeout();
    int n, b1, br;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i] = 32'hC0C0C0C0 + i;
      delay_cfg[i] = 1;
    end
    data_cfg[1] = 32'hDEADBEEF; delay_cfg[1] = 0;
    b1 = tot_hi[1]; br = rise_q.size();
    enable_mask = 4'hF;
    run_sweep(1, -1, n);
    total++; if (n !== 19) begin bad++; $display("FAIL to_latency got=%0d exp=19", n); end
    total++; if (tot_hi[1] - b1 !== TO) begin bad++; $display("FAIL to_strobe_len got=%0d exp=8", tot_hi[1] - b1); end
    total++; if (timeout_err !== 4'b0010) begin bad++; $display("FAIL to_err got=%b exp=0010", timeout_err); end
    total++; if (slot_values !== {32'hC0C0C0C3, 32'hC0C0C0C2, 32'h22222222, 32'hC0C0C0C0}) begin
      bad++; $display("FAIL to_values got=%h exp=c0c0c0c3c0c0c0c222222222c0c0c0c0", slot_values); end
    total++; if (slot_fresh !== 4'b1101) begin bad++; $display("FAIL to_fresh got=%b exp=1101", slot_fresh); end
    total++; if (rise_code(br) !== 1234) begin bad++; $display("FAIL to_order got=%0d exp=1234", rise_code(br)); end
    tick();
  endtask

  task automatic test_coincident();
    int n, b1;
    logic [WW-1:0] w;
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    total++; if (timeout_err !== 4'b0000) begin bad++; $display("FAIL co_clear got=%b exp=0000", timeout_err); end
    // done on the last allowed REQ cycle: capture wins
    for (int i = 0; i < NL; i++) delay_cfg[i] = 1;
    delay_cfg[1] = TO; data_cfg[1] = 32'h55555555;
    b1 = tot_hi[1];
    run_sweep(1, -1, n);
    w = slot_values[1*WW +: WW];
    total++; if (n !== 19) begin bad++; $display("FAIL co_latency got=%0d exp=19", n); end
    total++; if (w !== 32'h55555555) begin bad++; $display("FAIL co_capture got=%h exp=55555555", w); end
    total++; if (timeout_err !== 4'b0000) begin bad++; $display("FAIL co_no_err got=%b exp=0000", timeout_err); end
    total++; if (tot_hi[1] - b1 !== TO) begin bad++; $display("FAIL co_strobe_len got=%0d exp=8", tot_hi[1] - b1); end
    tick();
    // slot 0 times out first (bit 0 set), then err_clear meets slot 1 timeout
    delay_cfg[0] = 0; delay_cfg[1] = 0;
    run_sweep(1, 19, n);
    total++; if (n !== 26) begin bad++; $display("FAIL co2_latency got=%0d exp=26", n); end
    total++; if (timeout_err !== 4'b0010) begin bad++; $display("FAIL co2_err got=%b exp=0010", timeout_err); end
    w = slot_values[1*WW +: WW];
    total++; if (w !== 32'h55555555) begin bad++; $display("FAIL co2_hold got=%h exp=55555555", w); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    logic fresh_mid_ok, busy_mid;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i] = 32'h00000100 + i;
      delay_cfg[i] = 1;
    end
    enable_mask = 4'hF;
    run = 1'b1; n = 0; first = -1; second = -1; fresh_mid_ok = 1'b0; busy_mid = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (n == 13) begin
        fresh_mid_ok = (slot_fresh === 4'h0);
        busy_mid     = busy;
        run          = 1'b0;
      end
      if (sweep_done) begin
        if (first < 0) first = n;
        else begin second = n; break; end
      end
    end
    run = 1'b0;
    total++; if (first !== 12) begin bad++; $display("FAIL b2b_first got=%0d exp=12", first); end
    total++; if (second !== 24) begin bad++; $display("FAIL b2b_second got=%0d exp=24", second); end
    total++; if (!fresh_mid_ok || busy_mid !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b/%b exp=1/1", fresh_mid_ok, busy_mid); end
    total++; if (slot_fresh !== 4'hF) begin bad++; $display("FAIL b2b_fresh got=%h exp=f", slot_fresh); end
    tick();
  endtask

  task automatic test_run_drop();
    int n, b2, b3, bs;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i] = 32'hE0000000 + i;
      delay_cfg[i] = 1;
    end
    b2 = tot_hi[2]; b3 = tot_hi[3]; bs = sweep_cnt;
    run_sweep(5, -1, n);
    total++; if (n !== 12) begin bad++; $display("FAIL drop_latency got=%0d exp=12", n); end
    total++; if (tot_hi[2] - b2 !== 1 || tot_hi[3] - b3 !== 1) begin
      bad++; $display("FAIL drop_tail got=%0d,%0d exp=1,1", tot_hi[2] - b2, tot_hi[3] - b3); end
    total++; if (slot_values !== {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000}) begin
      bad++; $display("FAIL drop_values got=%h exp=e0000003e0000002e0000001e0000000", slot_values); end
    tick();
    total++; if (busy !== 1'b0 || read_strobe !== 4'h0) begin bad++; $display("FAIL drop_idle got=%b/%h exp=0/0", busy, read_strobe); end
    repeat (3) tick();
    total++; if (sweep_cnt - bs !== 1) begin bad++; $display("FAIL drop_sweep_cnt got=%0d exp=1", sweep_cnt - bs); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NL; i++) delay_cfg[i] = 0;
    enable_mask = 4'hF;
    // leave one timeout bit set so reset has something to clear
    err_clear = 1'b0;
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    total++; if (read_strobe !== 4'b0001) begin bad++; $display("FAIL mid_req_strobe got=%b exp=0001", read_strobe); end
    rstn = 1'b0;
    tick();
    total++; if (read_strobe !== 4'h0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got=%h/%b/%b exp=0/0/0", read_strobe, busy, sweep_done); end
    total++; if (slot_values !== '0 || slot_fresh !== 4'h0 || timeout_err !== 4'h0) begin
      bad++; $display("FAIL mid_rst_data got=%h/%h/%h exp=0/0/0", slot_values, slot_fresh, timeout_err); end
    rstn = 1'b1;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rstn = 1'b0; run = 1'b0; enable_mask = '0; err_clear = 1'b0;
    for (int i = 0; i < NL; i++) begin
      data_cfg[i]  = '0;
      delay_cfg[i] = 1;
    end
    test_reset();
    test_empty_mask();
    test_full_sweep();
    test_partial_mask();
    test_timeout();
    test_coincident();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
